// File: rtl/fir_pkg.sv
// Shared types and default widths for the FIR tap streamer and its shadow RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

   localparam int C_TAP_WIDTH     = 16;
   localparam int C_NUM_TAPS_LOG2 = 4;
   localparam int C_FLUSH_CYCLES  = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FLUSH     = 2'd1,
      STREAM    = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/fir_tap_shadow_ram.sv
// Shadow coefficient store: one write port, one synchronous read port, registered output.
// Latency: read data appears on rd_data_o one cycle after rd_en_i.
// Backpressure: none; the caller only issues reads it has room to absorb.
module fir_tap_shadow_ram
   import fir_pkg::*;
#(
   parameter int G_DATA_WIDTH = C_TAP_WIDTH,
   parameter int G_ADDR_WIDTH = C_NUM_TAPS_LOG2
)(
   input  logic                    clk_i,
   input  logic                    wr_en_i,
   input  logic [G_ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [G_DATA_WIDTH-1:0] wr_data_i,
   input  logic                    rd_en_i,
   input  logic [G_ADDR_WIDTH-1:0] rd_addr_i,
   output logic [G_DATA_WIDTH-1:0] rd_data_o
);

   logic [G_DATA_WIDTH-1:0] mem_q [2**G_ADDR_WIDTH];

   // Array write and registered read; contents deliberately have no reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_o <= mem_q[rd_addr_i];
      end
   end

endmodule

// File: rtl/fir_tap_streamer.sv
// Streams a shadow copy of all FIR coefficients into the FIR tap-programming port after a flush.
// Latency: start to first tap valid = G_FLUSH_CYCLES+2 cycles, then one tap per cycle with ready high.
// Backpressure: tap_dout held while valid&&!ready; a one-entry skid absorbs the RAM read latency.
// Optional: define FIR_TAP_STREAMER_CHECKSUM_EN to add the tap_checksum output.
module fir_tap_streamer
   import fir_pkg::*;
#(
   parameter int G_TAP_WIDTH     = C_TAP_WIDTH,
   parameter int G_NUM_TAPS_LOG2 = C_NUM_TAPS_LOG2,
   parameter int G_FLUSH_CYCLES  = C_FLUSH_CYCLES
)(
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [G_NUM_TAPS_LOG2-1:0] cfg_addr,
   input  logic [G_TAP_WIDTH-1:0]     cfg_wdata,
   input  logic                       cfg_wen,
   input  logic                       start,
   output logic                       busy,
   output logic                       load_done,
   output logic                       cfg_wr_err,
   output logic                       fir_enable,
   output logic [G_TAP_WIDTH-1:0]     tap_dout,
   output logic                       tap_dout_valid,
   input  logic                       tap_dout_ready,
   input  logic                       fir_tap_done
`ifdef FIR_TAP_STREAMER_CHECKSUM_EN
   ,
   output logic [G_TAP_WIDTH+G_NUM_TAPS_LOG2-1:0] tap_checksum
`endif
);

   // One extra address bit so "all taps issued" is a plain compare.
   localparam int                        AW       = G_NUM_TAPS_LOG2 + 1;
   localparam logic [AW-1:0]             END_ADDR = AW'(2**G_NUM_TAPS_LOG2);
   localparam int                        CNT_W    = (G_FLUSH_CYCLES > 1) ? $clog2(G_FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0]          FLUSH_LD = CNT_W'(G_FLUSH_CYCLES - 1);

   state_t                  state_q;
   logic [AW-1:0]           rd_addr_q;
   logic [CNT_W-1:0]        flush_cnt_q;
   logic                    fir_enable_q;
   logic                    load_done_q;
   logic                    cfg_wr_err_q;

   logic                    ram_vld_q;
   logic [G_TAP_WIDTH-1:0]  ram_rdata;
   logic [G_TAP_WIDTH-1:0]  skid_q, skid_d;
   logic                    skid_vld_q, skid_vld_d;
   logic [G_TAP_WIDTH-1:0]  dout_q, dout_d;
   logic                    dout_vld_q, dout_vld_d;

   logic                    out_fire;
   logic                    addr_left;
   logic [1:0]              occ;
   logic                    rd_en;
   logic                    last_fire;
   logic                    ram_we;

   fir_tap_shadow_ram #(
      .G_DATA_WIDTH (G_TAP_WIDTH),
      .G_ADDR_WIDTH (G_NUM_TAPS_LOG2)
   ) u_ram (
      .clk_i     (clk),
      .wr_en_i   (ram_we),
      .wr_addr_i (cfg_addr),
      .wr_data_i (cfg_wdata),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_addr_q[G_NUM_TAPS_LOG2-1:0]),
      .rd_data_o (ram_rdata)
   );

   // Read issue: a read is only launched if its data is guaranteed a slot
   // (output or skid) next cycle even if the consumer stalls.
   always_comb begin
      out_fire  = dout_vld_q & tap_dout_ready;
      addr_left = (rd_addr_q != END_ADDR);
      occ       = 2'(dout_vld_q) + 2'(skid_vld_q) + 2'(ram_vld_q) - 2'(out_fire);
      rd_en     = ((state_q == FLUSH) && (flush_cnt_q == '0)) ||
                  ((state_q == STREAM) && addr_left && (occ <= 2'd1));
      last_fire = (state_q == STREAM) && out_fire && !skid_vld_q && !ram_vld_q && !addr_left;
      ram_we    = cfg_wen && (state_q == IDLE);
   end

   // Output/skid steering: skid data always drains ahead of fresh RAM data.
   always_comb begin
      dout_d     = dout_q;
      dout_vld_d = dout_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (!dout_vld_q || tap_dout_ready) begin
         if (skid_vld_q) begin
            dout_d     = skid_q;
            dout_vld_d = 1'b1;
            if (ram_vld_q) begin
               skid_d = ram_rdata;
            end else begin
               skid_vld_d = 1'b0;
            end
         end else if (ram_vld_q) begin
            dout_d     = ram_rdata;
            dout_vld_d = 1'b1;
         end else begin
            dout_vld_d = 1'b0;
         end
      end else if (ram_vld_q) begin
         skid_d     = ram_rdata;
         skid_vld_d = 1'b1;
      end
   end

   // Datapath registers; a reset drops anything in flight immediately.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ram_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         ram_vld_q  <= rd_en;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
      end
   end

   // Control FSM with registered fir_enable, load_done and sticky write error.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rd_addr_q    <= '0;
         flush_cnt_q  <= '0;
         fir_enable_q <= 1'b0;
         load_done_q  <= 1'b0;
         cfg_wr_err_q <= 1'b0;
      end else begin
         load_done_q <= 1'b0;
         if (cfg_wen && (state_q != IDLE)) begin
            cfg_wr_err_q <= 1'b1;
         end
         if (rd_en) begin
            rd_addr_q <= rd_addr_q + AW'(1);
         end
         case (state_q)
            IDLE: begin
               fir_enable_q <= 1'b1;
               if (start) begin
                  state_q      <= FLUSH;
                  fir_enable_q <= 1'b0;
                  flush_cnt_q  <= FLUSH_LD;
                  cfg_wr_err_q <= 1'b0;
                  rd_addr_q    <= '0;
               end
            end
            FLUSH: begin
               if (flush_cnt_q == '0) begin
                  state_q      <= STREAM;
                  fir_enable_q <= 1'b1;
               end else begin
                  flush_cnt_q <= flush_cnt_q - CNT_W'(1);
               end
            end
            STREAM: begin
               if (last_fire) begin
                  state_q <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (fir_tap_done) begin
                  state_q     <= IDLE;
                  load_done_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef FIR_TAP_STREAMER_CHECKSUM_EN
   localparam int CSW = G_TAP_WIDTH + G_NUM_TAPS_LOG2;
   logic [CSW-1:0] checksum_q;

   // Running unsigned sum of transferred taps, cleared when a reload starts.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         checksum_q <= '0;
      end else if ((state_q == IDLE) && start) begin
         checksum_q <= '0;
      end else if (out_fire) begin
         checksum_q <= checksum_q + CSW'(dout_q);
      end
   end

   assign tap_checksum = checksum_q;
`endif

   assign busy           = (state_q != IDLE);
   assign load_done      = load_done_q;
   assign cfg_wr_err     = cfg_wr_err_q;
   assign fir_enable     = fir_enable_q;
   assign tap_dout       = dout_q;
   assign tap_dout_valid = dout_vld_q;

endmodule
